// File: rtl/integrator_rr_sched.sv
// Multi-channel saturating integrator. A round-robin arbiter feeds one shared
// adder through a grant/capture stage and an add/write-back stage.
module integrator_rr_sched #(
  parameter int unsigned NCH = 4,
  parameter int unsigned W   = 10,
  parameter int unsigned CW  = 2
) (
  input  logic             system1000,
  input  logic             system1000_rst,
  input  logic [NCH-1:0]   req_i,
  input  logic [NCH*W-1:0] sample_i,
  input  logic [NCH-1:0]   clr_i,
  output logic [NCH-1:0]   gnt_o,
  output logic             acc_valid_o,
  output logic [CW-1:0]    acc_ch_o,
  output logic [W-1:0]     acc_o,
  output logic             sat_o,
  output logic [NCH-1:0]   sat_sticky_o
);

  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  logic [CW-1:0] ptr;
  logic [CW-1:0] gnt_idx;
  logic          gnt_any;
  logic          grant;
  logic [CW-1:0] ptr_next;

  logic          s1_valid;
  logic [CW-1:0] s1_ch;
  logic [W-1:0]  s1_x;

  logic [W-1:0]  acc [NCH];
  logic [W-1:0]  smp [NCH];

  logic [W-1:0]  a;
  logic [W:0]    sum;
  logic          sat;
  logic [W-1:0]  r;

  // Unpack the flat sample bus into per-channel words.
  always_comb begin
    for (int unsigned k = 0; k < NCH; k++) begin
      smp[k] = sample_i[k*W +: W];
    end
  end

  // Round-robin search starting at ptr, wrapping modulo NCH.
  always_comb begin : arb
    int unsigned idx;
    logic [NCH-1:0] req_sh;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    req_sh  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NCH) idx = idx - NCH;
      req_sh = req_i >> idx;
      if (!gnt_any && req_sh[0]) begin
        gnt_any = 1'b1;
        gnt_idx = CW'(idx);
      end
    end
  end

  assign grant    = gnt_any & ~system1000_rst;
  assign gnt_o    = grant ? (NCH'(1) << gnt_idx) : '0;
  assign ptr_next = (32'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + CW'(1);

  // Saturating add; overflow is only possible when both operands share a sign.
  always_comb begin
    a   = acc[s1_ch];
    sum = {a[W-1], a} + {s1_x[W-1], s1_x};
    sat = (sum[W] != sum[W-1]);
    r   = sum[W-1:0];
    if (sat) r = (a[W-1] & s1_x[W-1]) ? SAT_MIN : SAT_MAX;
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      ptr          <= '0;
      s1_valid     <= 1'b0;
      s1_ch        <= '0;
      s1_x         <= '0;
      acc_valid_o  <= 1'b0;
      acc_ch_o     <= '0;
      acc_o        <= '0;
      sat_o        <= 1'b0;
      sat_sticky_o <= '0;
      for (int unsigned k = 0; k < NCH; k++) acc[k] <= '0;
    end else begin
      s1_valid <= grant;
      if (grant) begin
        ptr   <= ptr_next;
        s1_ch <= gnt_idx;
        s1_x  <= smp[gnt_idx];
      end
      acc_valid_o <= s1_valid;
      if (s1_valid) begin
        acc_ch_o   <= s1_ch;
        acc_o      <= r;
        sat_o      <= sat;
        acc[s1_ch] <= r;
        if (sat) sat_sticky_o[s1_ch] <= 1'b1;
      end
      // Clear overrides a same-edge write-back to the same channel.
      for (int unsigned k = 0; k < NCH; k++) begin
        if (clr_i[k]) begin
          acc[k]          <= '0;
          sat_sticky_o[k] <= 1'b0;
        end
      end
    end
  end

endmodule
